// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Screen geometry, coordinate/colour types and pixel record
//                shared by the VGA plotting path.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef logic [7:0] coord_x_t;
    typedef logic [6:0] coord_y_t;
    typedef logic [2:0] colour_t;

    typedef struct packed {
        coord_x_t x;
        coord_y_t y;
        colour_t  colour;
    } pixel_t;

    function automatic logic on_screen(input coord_x_t x, input coord_y_t y);
        return (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));
    endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/plot_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : plot_buffer
//  Description : Small pixel FIFO between a plotting engine and a VGA adapter;
//                drops off-screen pixels and counts them.
//  Revision    : 1.0 - initial release
// ============================================================================
module plot_buffer
    import vga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [7:0] in_x,
    input  logic [6:0] in_y,
    input  logic [2:0] in_colour,
    input  logic       in_plot,
    output logic       in_ready,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    input  logic       vga_ready,
    output logic [15:0] clip_count,
    output logic       empty
);

    localparam int                 c_addr_w  = $clog2(DEPTH);
    localparam logic [c_addr_w:0]  c_full    = (c_addr_w+1)'(DEPTH);
    localparam logic [c_addr_w:0]  c_cnt_one = (c_addr_w+1)'(1);
    localparam logic [c_addr_w-1:0] c_ptr_one = (c_addr_w)'(1);
    localparam logic [15:0]        c_clip_max = 16'hFFFF;

    pixel_t                r_mem [DEPTH];
    logic [c_addr_w-1:0]   r_head;
    logic [c_addr_w-1:0]   r_tail;
    logic [c_addr_w:0]     r_count;
    logic [15:0]           r_clip_count;

    logic   w_full;
    logic   w_empty;
    logic   w_accept;
    logic   w_push;
    logic   w_clip;
    logic   w_pop;
    pixel_t w_in_pix;
    pixel_t w_head_pix;

    assign w_full   = (r_count == c_full);
    assign w_empty  = (r_count == '0);
    assign w_in_pix = '{x: in_x, y: in_y, colour: in_colour};

    // clear wins over everything in its cycle, so it masks accept and pop
    assign w_accept = in_plot && !w_full && !clear;
    assign w_push   = w_accept && on_screen(in_x, in_y);
    assign w_clip   = w_accept && !on_screen(in_x, in_y);
    assign w_pop    = !w_empty && vga_ready && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_ptr_one;
            end
            if (w_pop) begin
                r_head <= r_head + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clip_count <= '0;
        end else if (w_clip && (r_clip_count != c_clip_max)) begin
            r_clip_count <= r_clip_count + 16'd1;
        end
    end

    // Storage is left unreset; the output mux below hides stale contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= w_in_pix;
        end
    end

    assign w_head_pix = r_mem[r_head];

    assign in_ready   = !w_full;
    assign empty      = w_empty;
    assign vga_plot   = !w_empty;
    assign vga_x      = w_empty ? '0 : w_head_pix.x;
    assign vga_y      = w_empty ? '0 : w_head_pix.y;
    assign vga_colour = w_empty ? '0 : w_head_pix.colour;
    assign clip_count = r_clip_count;

endmodule : plot_buffer
`default_nettype wire

// File: tb/tb_plot_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_plot_buffer
//  Description : Self-checking bench for plot_buffer: directed vector table,
//                corner-case sequences and a randomized queue-model run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plot_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        r_rst = 1'b1;
    logic        r_clear = 1'b0;
    logic [7:0]  r_in_x = '0;
    logic [6:0]  r_in_y = '0;
    logic [2:0]  r_in_colour = '0;
    logic        r_in_plot = 1'b0;
    logic        r_vga_ready = 1'b0;
    logic        w_in_ready;
    logic [7:0]  w_vga_x;
    logic [6:0]  w_vga_y;
    logic [2:0]  w_vga_colour;
    logic        w_vga_plot;
    logic [15:0] w_clip_count;
    logic        w_empty;

    int n_checks = 0;
    int n_errors = 0;

    plot_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (r_rst),
        .clear      (r_clear),
        .in_x       (r_in_x),
        .in_y       (r_in_y),
        .in_colour  (r_in_colour),
        .in_plot    (r_in_plot),
        .in_ready   (w_in_ready),
        .vga_x      (w_vga_x),
        .vga_y      (w_vga_y),
        .vga_colour (w_vga_colour),
        .vga_plot   (w_vga_plot),
        .vga_ready  (r_vga_ready),
        .clip_count (w_clip_count),
        .empty      (w_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pix(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        return {14'd0, x, y, c};
    endfunction

    task automatic drive(input logic plot, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c, input logic rdy, input logic clr);
        r_in_plot   = plot;
        r_in_x      = x;
        r_in_y      = y;
        r_in_colour = c;
        r_vga_ready = rdy;
        r_clear     = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        plot;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  c;
        logic        rdy;
        logic        clr;
        logic        e_ready;
        logic        e_vplot;
        logic [7:0]  e_x;
        logic [6:0]  e_y;
        logic [2:0]  e_c;
        logic        e_empty;
        logic [15:0] e_clip;
    } vec_t;

    function automatic vec_t mv(input logic plot, input int x, input int y, input int c,
                                input logic rdy, input logic clr,
                                input logic er, input logic ep, input int ex, input int ey,
                                input int ec, input logic ee, input int eclip);
        vec_t v;
        v.plot = plot; v.x = 8'(x); v.y = 7'(y); v.c = 3'(c); v.rdy = rdy; v.clr = clr;
        v.e_ready = er; v.e_vplot = ep; v.e_x = 8'(ex); v.e_y = 7'(ey); v.e_c = 3'(ec);
        v.e_empty = ee; v.e_clip = 16'(eclip);
        return v;
    endfunction

    // Expectations in each row describe the state before that row's edge.
    vec_t vt [25];

    initial begin
        logic [17:0] q [$];
        logic [17:0] prev;
        logic        prev_valid;
        int          mclip;
        int          sweep_bad;
        int          out_cnt;

        vt[0]  = mv(1, 5, 7, 3,    1, 0,  1, 0, 0, 0, 0, 1, 0);
        vt[1]  = mv(0, 0, 0, 0,    1, 0,  1, 1, 5, 7, 3, 0, 0);
        vt[2]  = mv(0, 0, 0, 0,    1, 0,  1, 0, 0, 0, 0, 1, 0);
        vt[3]  = mv(1, 10, 1, 1,   0, 0,  1, 0, 0, 0, 0, 1, 0);
        vt[4]  = mv(1, 20, 2, 2,   0, 0,  1, 1, 10, 1, 1, 0, 0);
        vt[5]  = mv(1, 30, 3, 3,   0, 0,  1, 1, 10, 1, 1, 0, 0);
        vt[6]  = mv(1, 40, 4, 4,   0, 0,  1, 1, 10, 1, 1, 0, 0);
        vt[7]  = mv(1, 50, 5, 5,   0, 0,  0, 1, 10, 1, 1, 0, 0);
        vt[8]  = mv(1, 50, 5, 5,   0, 0,  0, 1, 10, 1, 1, 0, 0);
        vt[9]  = mv(1, 50, 5, 5,   1, 0,  0, 1, 10, 1, 1, 0, 0);
        vt[10] = mv(1, 50, 5, 5,   1, 0,  1, 1, 20, 2, 2, 0, 0);
        vt[11] = mv(0, 0, 0, 0,    1, 0,  1, 1, 30, 3, 3, 0, 0);
        vt[12] = mv(0, 0, 0, 0,    1, 0,  1, 1, 40, 4, 4, 0, 0);
        vt[13] = mv(0, 0, 0, 0,    1, 0,  1, 1, 50, 5, 5, 0, 0);
        vt[14] = mv(0, 0, 0, 0,    1, 0,  1, 0, 0, 0, 0, 1, 0);
        vt[15] = mv(1, 160, 0, 1,  1, 0,  1, 0, 0, 0, 0, 1, 0);
        vt[16] = mv(1, 0, 120, 2,  1, 0,  1, 0, 0, 0, 0, 1, 1);
        vt[17] = mv(1, 200, 127, 7,1, 0,  1, 0, 0, 0, 0, 1, 2);
        vt[18] = mv(0, 0, 0, 0,    1, 0,  1, 0, 0, 0, 0, 1, 3);
        vt[19] = mv(1, 1, 1, 1,    0, 0,  1, 0, 0, 0, 0, 1, 3);
        vt[20] = mv(1, 2, 2, 2,    0, 0,  1, 1, 1, 1, 1, 0, 3);
        vt[21] = mv(1, 3, 3, 3,    0, 0,  1, 1, 1, 1, 1, 0, 3);
        vt[22] = mv(1, 170, 4, 4,  1, 1,  1, 1, 1, 1, 1, 0, 3);
        vt[23] = mv(0, 0, 0, 0,    1, 0,  1, 0, 0, 0, 0, 1, 3);
        vt[24] = mv(0, 0, 0, 0,    1, 0,  1, 0, 0, 0, 0, 1, 3);

        // Reset state, observed before any clock edge.
        #2;
        chk("rst_vga_plot", 32'(w_vga_plot), 0);
        chk("rst_empty", 32'(w_empty), 1);
        chk("rst_in_ready", 32'(w_in_ready), 1);
        chk("rst_pixel", pix(w_vga_x, w_vga_y, w_vga_colour), 0);
        chk("rst_clip", 32'(w_clip_count), 0);
        tick();
        tick();
        r_rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            drive(vt[i].plot, vt[i].x, vt[i].y, vt[i].c, vt[i].rdy, vt[i].clr);
            chk($sformatf("v%0d_in_ready", i), 32'(w_in_ready), 32'(vt[i].e_ready));
            chk($sformatf("v%0d_vga_plot", i), 32'(w_vga_plot), 32'(vt[i].e_vplot));
            chk($sformatf("v%0d_pixel", i), pix(w_vga_x, w_vga_y, w_vga_colour),
                pix(vt[i].e_x, vt[i].e_y, vt[i].e_c));
            chk($sformatf("v%0d_empty", i), 32'(w_empty), 32'(vt[i].e_empty));
            chk($sformatf("v%0d_clip", i), 32'(w_clip_count), 32'(vt[i].e_clip));
            tick();
        end

        // Asynchronous reset in the middle of a stream.
        drive(1, 8'd11, 7'd11, 3'd1, 0, 0);
        tick();
        drive(1, 8'd12, 7'd12, 3'd2, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("mid_pre_vga_plot", 32'(w_vga_plot), 1);
        #3;
        r_rst = 1'b1;
        #1;
        chk("mid_rst_vga_plot", 32'(w_vga_plot), 0);
        chk("mid_rst_empty", 32'(w_empty), 1);
        chk("mid_rst_in_ready", 32'(w_in_ready), 1);
        chk("mid_rst_pixel", pix(w_vga_x, w_vga_y, w_vga_colour), 0);
        chk("mid_rst_clip", 32'(w_clip_count), 0);
        @(posedge clk);
        #2;
        r_rst = 1'b0;
        drive(1, 8'd9, 7'd9, 3'd6, 1, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        chk("post_rst_vga_plot", 32'(w_vga_plot), 1);
        chk("post_rst_pixel", pix(w_vga_x, w_vga_y, w_vga_colour), pix(8'd9, 7'd9, 3'd6));
        tick();
        chk("post_rst_empty", 32'(w_empty), 1);

        // Clip counter saturation.
        drive(1, 8'd200, 7'd0, 3'd0, 1, 0);
        repeat (65535) @(posedge clk);
        #1;
        chk("sat_clip_max", 32'(w_clip_count), 32'hFFFF);
        chk("sat_empty", 32'(w_empty), 1);
        tick();
        chk("sat_clip_hold", 32'(w_clip_count), 32'hFFFF);
        drive(0, 0, 0, 0, 1, 0);
        tick();

        // Full-screen sweep with the adapter always ready: each pixel must
        // appear exactly one cycle after it is pushed.
        sweep_bad  = 0;
        out_cnt    = 0;
        prev_valid = 1'b0;
        prev       = '0;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                drive(1, 8'(x), 7'(y), 3'((x + y) % 8), 1, 0);
                if (prev_valid) begin
                    if (w_vga_plot === 1'b1 && {w_vga_x, w_vga_y, w_vga_colour} === prev)
                        out_cnt++;
                    else
                        sweep_bad++;
                end else if (w_vga_plot !== 1'b0) begin
                    sweep_bad++;
                end
                if (w_in_ready !== 1'b1) sweep_bad++;
                prev       = {8'(x), 7'(y), 3'((x + y) % 8)};
                prev_valid = 1'b1;
                tick();
            end
        end
        drive(0, 0, 0, 0, 1, 0);
        if (w_vga_plot === 1'b1 && {w_vga_x, w_vga_y, w_vga_colour} === prev) out_cnt++;
        else sweep_bad++;
        tick();
        chk("sweep_bad_cycles", 32'(sweep_bad), 0);
        chk("sweep_out_count", 32'(out_cnt), 19200);
        chk("sweep_end_empty", 32'(w_empty), 1);

        // Randomized traffic against a queue model.
        r_rst = 1'b1;
        #2;
        r_rst = 1'b0;
        tick();
        q.delete();
        mclip = 0;
        for (int n = 0; n < 1500; n++) begin
            logic       plot, rdy, clr;
            logic [7:0] x;
            logic [6:0] y;
            logic [2:0] c;
            int         sz;
            plot = ($urandom_range(0, 3) != 0);
            x    = 8'($urandom_range(0, 175));
            y    = 7'($urandom_range(0, 127));
            c    = 3'($urandom_range(0, 7));
            rdy  = ($urandom_range(0, 2) == 0);
            clr  = ($urandom_range(0, 49) == 0);
            drive(plot, x, y, c, rdy, clr);
            sz = q.size();
            chk($sformatf("rnd%0d_vga_plot", n), 32'(w_vga_plot), 32'(sz > 0));
            chk($sformatf("rnd%0d_in_ready", n), 32'(w_in_ready), 32'(sz < DEPTH));
            chk($sformatf("rnd%0d_empty", n), 32'(w_empty), 32'(sz == 0));
            chk($sformatf("rnd%0d_pixel", n), pix(w_vga_x, w_vga_y, w_vga_colour),
                (sz > 0) ? {14'd0, q[0]} : 32'd0);
            chk($sformatf("rnd%0d_clip", n), 32'(w_clip_count), 32'(mclip));
            if (clr) begin
                q.delete();
            end else begin
                if (sz > 0 && rdy) void'(q.pop_front());
                if (plot && sz < DEPTH) begin
                    if (x < 160 && y < 120) q.push_back({x, y, c});
                    else if (mclip < 65535) mclip++;
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_plot_buffer
`default_nettype wire

// File: doc/plot_buffer.md
PLOT_BUFFER -- requirements
Module: plot_buffer

Interface
REQ-001 Parameter DEPTH, default 4, meaning: number of pixel entries stored; SHALL be a power of two, 2 to 16.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 clear  input  1  synchronous flush of all stored pixels.
REQ-005 in_x  input  8  upstream pixel column.
REQ-006 in_y  input  7  upstream pixel row.
REQ-007 in_colour  input  3  upstream pixel colour.
REQ-008 in_plot  input  1  upstream pixel valid.
REQ-009 in_ready  output  1  buffer can take a pixel this cycle.
REQ-010 vga_x  output  8  column to the VGA adapter.
REQ-011 vga_y  output  7  row to the VGA adapter.
REQ-012 vga_colour  output  3  colour to the VGA adapter.
REQ-013 vga_plot  output  1  pixel on vga_* is valid.
REQ-014 vga_ready  input  1  adapter accepts the presented pixel.
REQ-015 clip_count  output  16  number of discarded off-screen pixels.
REQ-016 empty  output  1  no pixels stored.

Function
REQ-017 Accept SHALL occur when in_plot && in_ready; in_ready SHALL equal ~full, depending only on internal state.
REQ-018 On accept with in_x <= 159 and in_y <= 119, the pixel SHALL be written at the tail and the tail pointer advanced modulo DEPTH.
REQ-019 On accept with in_x > 159 or in_y > 119, the pixel SHALL NOT be stored and clip_count SHALL increment, saturating at 16'hFFFF.
REQ-020 vga_plot SHALL equal ~empty; vga_x/vga_y/vga_colour SHALL present the head entry, driven from storage with no combinational path from in_*.
REQ-021 Pop SHALL occur when vga_plot && vga_ready; the head pointer SHALL advance modulo DEPTH.
REQ-022 Latency SHALL be one cycle: a pixel accepted into an empty buffer SHALL appear on vga_* with vga_plot=1 on the following cycle.
REQ-023 Occupancy SHALL be tracked in a counter of width $clog2(DEPTH)+1; full = (count == DEPTH), empty = (count == 0).
REQ-024 Simultaneous push and pop SHALL leave count unchanged; simultaneous push and pop at count==1 SHALL keep vga_plot=1 and present the new pixel next cycle.
REQ-025 When full, no accept SHALL occur in that cycle, even if a pop occurs in the same cycle.
REQ-026 Pixels SHALL leave in acceptance order; none SHALL be duplicated or lost except by clip or clear.
REQ-027 clear=1 SHALL reset head, tail and count to 0 on the next edge; clip_count SHALL be held; any accept or pop in that cycle SHALL be ignored.
REQ-028 While vga_plot=1 and vga_ready=0, vga_x, vga_y and vga_colour SHALL hold stable.

Reset
REQ-029 On rst=1, regardless of clk: head, tail, count=0, clip_count=0, vga_plot=0, empty=1, in_ready=1.
REQ-030 vga_x, vga_y and vga_colour SHALL read 0 during reset; storage contents need not be reset.
REQ-031 Reset asserted mid-transfer SHALL discard all stored pixels; operation SHALL resume on the first edge after rst deasserts.

Structure
REQ-032 Package vga_pkg SHALL hold SCREEN_W=160, SCREEN_H=120, the coordinate and colour typedefs, and a packed pixel struct {x, y, colour}.
REQ-033 No sub-module is required; the storage array, pointers and counters SHALL reside in plot_buffer.

Verification
REQ-034 Reset, then push (5,7,3) with vga_ready=1 -> vga_plot=1 with (5,7,3) the next cycle, empty=1 one cycle after that.
REQ-035 vga_ready=0, push 5 on-screen pixels, DEPTH=4 -> in_ready=0 after the 4th accept, 5th held; raise vga_ready -> 5 pixels out in order.
REQ-036 Push (160,0), (0,120) and (200,127) -> nothing output, clip_count=3; preload 16'hFFFF, clip once -> stays 16'hFFFF.
REQ-037 Continuous push plus vga_ready=1 over a full 160x120 sweep -> 19200 pixels out in order, count never exceeds 1.
REQ-038 Fill 3 entries, assert clear together with in_plot -> empty=1 next cycle, clip_count unchanged, no pixel emitted.
REQ-039 Assert rst mid-stream between clock edges -> vga_plot=0 immediately; the next push after release appears with 1-cycle latency.
